// File: rtl/tessent_ijtag_override_mux_tdr.sv
`default_nettype none
// ============================================================================
// Module : tessent_ijtag_override_mux_tdr
// Brief  : IJTAG TDR with per-channel enable that overrides functional data.
// Rev    : 1.0  initial release
// ============================================================================
module tessent_ijtag_override_mux_tdr #(
  parameter int WIDTH        = 19,
  parameter int NUM_CH       = 2,
  parameter int CAPTURE_FUNC = 1
) (
  input  logic                    ijtag_tck,
  input  logic                    ijtag_reset,
  input  logic                    ijtag_sel,
  input  logic                    ijtag_ce,
  input  logic                    ijtag_se,
  input  logic                    ijtag_ue,
  input  logic                    ijtag_si,
  output logic                    ijtag_so,
  input  logic [NUM_CH*WIDTH-1:0] functional_data_in,
  output logic [NUM_CH*WIDTH-1:0] data_out,
  output logic [NUM_CH-1:0]       override_active
);

  localparam int c_CH_LEN = WIDTH + 1;
  localparam int c_SR_LEN = NUM_CH * c_CH_LEN;
  localparam int c_DW     = NUM_CH * WIDTH;

  logic [c_SR_LEN-1:0] r_sr;
  logic [c_DW-1:0]     r_ud;
  logic [NUM_CH-1:0]   r_ue;

  logic [c_SR_LEN-1:0] w_capture;
  logic [c_DW-1:0]     w_sr_data;
  logic [NUM_CH-1:0]   w_sr_en;
  logic [c_DW-1:0]     w_cap_src;

  // Capture source: live functional data or update-stage readback.
  generate
    if (CAPTURE_FUNC != 0) begin : g_cap_func
      assign w_cap_src = functional_data_in;
    end else begin : g_cap_ud
      assign w_cap_src = r_ud;
    end
  endgenerate

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      assign w_capture[k*c_CH_LEN +: WIDTH]   = w_cap_src[k*WIDTH +: WIDTH];
      assign w_capture[k*c_CH_LEN + WIDTH]    = r_ue[k];
      assign w_sr_data[k*WIDTH +: WIDTH]      = r_sr[k*c_CH_LEN +: WIDTH];
      assign w_sr_en[k]                       = r_sr[k*c_CH_LEN + WIDTH];
      assign data_out[k*WIDTH +: WIDTH]       = r_ue[k] ? r_ud[k*WIDTH +: WIDTH]
                                                        : functional_data_in[k*WIDTH +: WIDTH];
    end
  endgenerate

  // Update samples the pre-edge shift register, so ue+se updates then shifts.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      r_sr <= '0;
      r_ud <= '0;
      r_ue <= '0;
    end else if (ijtag_sel) begin
      if (ijtag_ce) begin
        r_sr <= w_capture;
      end else if (ijtag_se) begin
        r_sr <= {ijtag_si, r_sr[c_SR_LEN-1:1]};
      end
      if (ijtag_ue) begin
        r_ud <= w_sr_data;
        r_ue <= w_sr_en;
      end
    end
  end

  assign ijtag_so        = r_sr[0];
  assign override_active = r_ue;

endmodule
`default_nettype wire

// File: tb/tb_tessent_ijtag_override_mux_tdr.sv
`default_nettype none
// ============================================================================
// Module : tb_tessent_ijtag_override_mux_tdr
// Brief  : Directed bench for both capture modes with a scan-out scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
module tb_tessent_ijtag_override_mux_tdr;

  localparam int W  = 19;
  localparam int N  = 2;
  localparam int SR = 40;
  localparam int DW = 38;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          sel   = 1'b0;
  logic          ce    = 1'b0;
  logic          se    = 1'b0;
  logic          ue    = 1'b0;
  logic          si    = 1'b0;
  logic [DW-1:0] func  = '0;

  wire           so_a, so_b;
  wire [DW-1:0]  do_a, do_b;
  wire [N-1:0]   ov_a, ov_b;

  int checks   = 0;
  int failures = 0;
  bit q_a[$];
  bit q_b[$];

  logic [SR-1:0] pat1, pat2, exp_a, exp_b;

  always #5 clk = ~clk;

  tessent_ijtag_override_mux_tdr #(.WIDTH(W), .NUM_CH(N), .CAPTURE_FUNC(1)) u_dut_a (
    .ijtag_tck(clk), .ijtag_reset(rst_n), .ijtag_sel(sel), .ijtag_ce(ce),
    .ijtag_se(se), .ijtag_ue(ue), .ijtag_si(si), .ijtag_so(so_a),
    .functional_data_in(func), .data_out(do_a), .override_active(ov_a)
  );

  tessent_ijtag_override_mux_tdr #(.WIDTH(W), .NUM_CH(N), .CAPTURE_FUNC(0)) u_dut_b (
    .ijtag_tck(clk), .ijtag_reset(rst_n), .ijtag_sel(sel), .ijtag_ce(ce),
    .ijtag_se(se), .ijtag_ue(ue), .ijtag_si(si), .ijtag_so(so_b),
    .functional_data_in(func), .data_out(do_b), .override_active(ov_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ov_a"}, 64'(ov_a), 64'(0));
    chk({tag, "_ov_b"}, 64'(ov_b), 64'(0));
    chk({tag, "_so_a"}, 64'(so_a), 64'(0));
    chk({tag, "_so_b"}, 64'(so_b), 64'(0));
    chk({tag, "_do_a"}, 64'(do_a), 64'(func));
    chk({tag, "_do_b"}, 64'(do_b), 64'(func));
  endtask

  initial begin
    pat1  = {1'b1, 19'h5A5A5, 1'b0, 19'h7FFFF};
    pat2  = {1'b0, 19'h12121, 1'b1, 19'h3C3C3};
    exp_a = {1'b1, 19'h00ABC, 1'b0, 19'h12345};
    exp_b = {1'b1, 19'h5A5A5, 1'b0, 19'h7FFFF};

    // Test 1: reset, then deselected activity has no effect.
    #1 rst_n = 1'b0;
    func = DW'({$urandom(), $urandom()});
    #2 chk_idle("reset");
    tick();
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sel = 1'b0;
      {ue, se, ce} = 3'(i + 1);
      si   = 1'b1;
      func = DW'({$urandom(), $urandom()});
      tick();
      chk_idle("desel");
    end
    {ue, se, ce} = 3'b000;

    // Test 2: load ch1 override, ch0 pass-through.
    sel = 1'b1;
    se  = 1'b1;
    for (int i = 0; i < SR; i++) begin
      si = pat1[i];
      tick();
      chk("shift1_ov", 64'(ov_a), 64'(0));
    end
    se = 1'b0;
    ue = 1'b1;
    tick();
    ue = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("t2_ch1", 64'((d == 0) ? do_a[37:19] : do_b[37:19]), 64'(19'h5A5A5));
      chk("t2_ch0", 64'((d == 0) ? do_a[18:0]  : do_b[18:0]),  64'(func[18:0]));
      chk("t2_ov",  64'((d == 0) ? ov_a : ov_b),               64'(2'b10));
    end

    // Test 3/4: capture (ce wins over se) and shift out; new pattern shifts in.
    func = {19'h00ABC, 19'h12345};
    for (int i = 0; i < SR; i++) begin
      q_a.push_back(exp_a[i]);
      q_b.push_back(exp_b[i]);
    end
    ce = 1'b1;
    se = 1'b1;
    tick();
    ce = 1'b0;
    for (int i = 0; i < SR; i++) begin
      chk("cap_so_a", 64'(so_a), 64'(q_a.pop_front()));
      chk("cap_so_b", 64'(so_b), 64'(q_b.pop_front()));
      chk("hold_ch1", 64'(do_a[37:19]), 64'(19'h5A5A5));
      si = pat2[i];
      se = 1'b1;
      tick();
    end

    // Test 5: update and shift in the same cycle.
    si = 1'b0;
    se = 1'b1;
    ue = 1'b1;
    tick();
    se = 1'b0;
    ue = 1'b0;
    chk("t5_ov_a",  64'(ov_a),        64'(2'b01));
    chk("t5_ov_b",  64'(ov_b),        64'(2'b01));
    chk("t5_ch0_a", 64'(do_a[18:0]),  64'(19'h3C3C3));
    chk("t5_ch0_b", 64'(do_b[18:0]),  64'(19'h3C3C3));
    chk("t5_ch1_a", 64'(do_a[37:19]), 64'(19'h00ABC));
    chk("t5_so_a",  64'(so_a),        64'(pat2[1]));
    chk("t5_so_b",  64'(so_b),        64'(pat2[1]));

    // Test 6: asynchronous reset in the middle of a shift.
    se = 1'b1;
    si = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    #2 rst_n = 1'b0;
    #1 chk_idle("midreset");
    tick();
    @(negedge clk) rst_n = 1'b1;
    si = 1'b0;
    for (int i = 0; i < SR; i++) begin
      q_a.push_back(1'b0);
      q_b.push_back(1'b0);
    end
    for (int i = 0; i < SR; i++) begin
      chk("post_so_a", 64'(so_a), 64'(q_a.pop_front()));
      chk("post_so_b", 64'(so_b), 64'(q_b.pop_front()));
      tick();
    end
    se = 1'b0;
    chk_idle("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
